// File: rtl/dt_param_engine.sv
// Two-pass chamfer distance-transform engine: reads a packed binary image from STI ROM
// and writes the saturated chessboard or city-block distance to background into RES RAM.
module dt_param_engine #(
    parameter int W_LOG2  = 7,
    parameter int H_LOG2  = 7,
    parameter int SW_LOG2 = 4,
    parameter int DIST_W  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    output logic                              busy,
    output logic                              done,
    output logic                              sti_rd,
    output logic [W_LOG2+H_LOG2-SW_LOG2-1:0]  sti_addr,
    input  logic [(1<<SW_LOG2)-1:0]           sti_di,
    output logic                              res_rd,
    output logic                              res_wr,
    output logic [W_LOG2+H_LOG2-1:0]          res_addr,
    output logic [DIST_W-1:0]                 res_do,
    input  logic [DIST_W-1:0]                 res_di
);

    localparam int SW   = 1 << SW_LOG2;
    localparam int RA_W = W_LOG2 + H_LOG2;
    localparam logic [DIST_W-1:0] DMAX = '1;

    // Neighbour offset codes for row/column: minus one, zero, plus one.
    localparam logic [1:0] OFF_M = 2'd0;
    localparam logic [1:0] OFF_Z = 2'd1;
    localparam logic [1:0] OFF_P = 2'd2;

    typedef enum logic [2:0] {
        IDLE, FETCH, FWD_RD, FWD_WR, BWD_RD, BWD_WR, DONE_ST
    } state_t;

    state_t              state, state_n;
    logic                mode_q, mode_n;
    logic [RA_W-1:0]     pos, pos_n;
    logic [SW-1:0]       word_q, word_n;
    logic [2:0]          slot, slot_n;
    logic [DIST_W-1:0]   min_q, min_n;
    logic [DIST_W-1:0]   self_q, self_n;

    logic [H_LOG2-1:0]   row, nbr_row;
    logic [W_LOG2-1:0]   col, nbr_col;
    logic [SW_LOG2-1:0]  pix, pix_n;
    logic [1:0]          dr, dc;
    logic                in_img, rd_slot;
    logic [DIST_W-1:0]   rd_val, new_min, inc, bwd_val;
    logic [DIST_W:0]     sum;

    assign row   = pos[RA_W-1:W_LOG2];
    assign col   = pos[W_LOG2-1:0];
    assign pix   = col[SW_LOG2-1:0];
    assign pix_n = pix + 1'b1;

    // Neighbour selection per read slot; backward slot 0 is the pixel itself.
    always_comb begin
        dr = OFF_Z;
        dc = OFF_Z;
        if (state == FWD_RD) begin
            if (mode_q) begin
                case (slot)
                    3'd0:    dr = OFF_M;
                    3'd1:    dc = OFF_M;
                    default: ;
                endcase
            end else begin
                case (slot)
                    3'd0:    begin dr = OFF_M; dc = OFF_M; end
                    3'd1:    dr = OFF_M;
                    3'd2:    begin dr = OFF_M; dc = OFF_P; end
                    3'd3:    dc = OFF_M;
                    default: ;
                endcase
            end
        end else if (state == BWD_RD) begin
            if (mode_q) begin
                case (slot)
                    3'd1:    dc = OFF_P;
                    3'd2:    dr = OFF_P;
                    default: ;
                endcase
            end else begin
                case (slot)
                    3'd1:    dc = OFF_P;
                    3'd2:    begin dr = OFF_P; dc = OFF_M; end
                    3'd3:    dr = OFF_P;
                    3'd4:    begin dr = OFF_P; dc = OFF_P; end
                    default: ;
                endcase
            end
        end
    end

    assign nbr_row = (dr == OFF_M) ? row - 1'b1 : (dr == OFF_P) ? row + 1'b1 : row;
    assign nbr_col = (dc == OFF_M) ? col - 1'b1 : (dc == OFF_P) ? col + 1'b1 : col;
    assign in_img  = !((dr == OFF_M && row == '0) || (dr == OFF_P && &row) ||
                       (dc == OFF_M && col == '0) || (dc == OFF_P && &col));
    assign rd_slot = (state == FWD_RD) || (state == BWD_RD);

    // Pixels outside the image count as background (distance 0).
    assign rd_val  = in_img ? res_di : '0;
    assign new_min = (rd_val < min_q) ? rd_val : min_q;
    assign sum     = {1'b0, min_q} + 1'b1;
    assign inc     = sum[DIST_W] ? DMAX : sum[DIST_W-1:0];
    assign bwd_val = (self_q < inc) ? self_q : inc;

    // Control handshake: start is honoured only while busy is low; busy stays high from the
    // cycle after acceptance through the single-cycle done pulse, then drops with done.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        pos_n   = pos;
        word_n  = word_q;
        slot_n  = slot;
        min_n   = min_q;
        self_n  = self_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    mode_n  = mode;
                    pos_n   = '0;
                    slot_n  = '0;
                    min_n   = DMAX;
                end
            end
            FETCH: begin
                word_n  = sti_di;
                slot_n  = '0;
                min_n   = DMAX;
                state_n = sti_di[SW-1] ? FWD_RD : FWD_WR;
            end
            FWD_RD: begin
                min_n  = new_min;
                slot_n = slot + 3'd1;
                if (slot == (mode_q ? 3'd1 : 3'd3)) state_n = FWD_WR;
            end
            FWD_WR: begin
                slot_n = '0;
                min_n  = DMAX;
                if (&pos) begin
                    state_n = BWD_RD;
                end else begin
                    pos_n = pos + 1'b1;
                    if (&pix)               state_n = FETCH;
                    else if (word_q[~pix_n]) state_n = FWD_RD;
                    else                     state_n = FWD_WR;
                end
            end
            BWD_RD: begin
                if (slot == 3'd0) begin
                    self_n = res_di;
                    min_n  = DMAX;
                    if (res_di == '0) begin
                        if (pos == '0) state_n = DONE_ST;
                        else           pos_n   = pos - 1'b1;
                    end else begin
                        slot_n = 3'd1;
                    end
                end else begin
                    min_n  = new_min;
                    slot_n = slot + 3'd1;
                    if (slot == (mode_q ? 3'd2 : 3'd4)) state_n = BWD_WR;
                end
            end
            BWD_WR: begin
                slot_n = '0;
                if (pos == '0) begin
                    state_n = DONE_ST;
                end else begin
                    pos_n   = pos - 1'b1;
                    state_n = BWD_RD;
                end
            end
            DONE_ST: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            pos    <= '0;
            word_q <= '0;
            slot   <= '0;
            min_q  <= '0;
            self_q <= '0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            pos    <= pos_n;
            word_q <= word_n;
            slot   <= slot_n;
            min_q  <= min_n;
            self_q <= self_n;
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE_ST);
        sti_rd   = (state == FETCH);
        sti_addr = (state == FETCH) ? pos[RA_W-1:SW_LOG2] : '0;
        res_rd   = rd_slot && in_img;
        res_wr   = (state == FWD_WR) || (state == BWD_WR);
        res_addr = '0;
        if (rd_slot && in_img) res_addr = {nbr_row, nbr_col};
        else if (rd_slot || res_wr) res_addr = pos;
        res_do = '0;
        if (state == FWD_WR)      res_do = word_q[~pix] ? inc : '0;
        else if (state == BWD_WR) res_do = bwd_val;
    end

endmodule

// File: tb/tb_dt_param_engine.sv
// Self-checking bench for dt_param_engine on a reduced 32x32 image with 8-pixel STI words and
// 3-bit distances; results are compared with a nearest-background search model.
module tb_dt_param_engine;

    localparam int W_LOG2  = 5;
    localparam int H_LOG2  = 5;
    localparam int SW_LOG2 = 3;
    localparam int DIST_W  = 3;
    localparam int W       = 1 << W_LOG2;
    localparam int H       = 1 << H_LOG2;
    localparam int SW      = 1 << SW_LOG2;
    localparam int N       = W * H;
    localparam int NWORDS  = N / SW;
    localparam int WPR     = W / SW;
    localparam int DMAX    = (1 << DIST_W) - 1;
    localparam int SA_W    = W_LOG2 + H_LOG2 - SW_LOG2;
    localparam int RA_W    = W_LOG2 + H_LOG2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic              sti_rd;
    logic [SA_W-1:0]   sti_addr;
    logic [SW-1:0]     sti_di;
    logic              res_rd;
    logic              res_wr;
    logic [RA_W-1:0]   res_addr;
    logic [DIST_W-1:0] res_do;
    logic [DIST_W-1:0] res_di;

    bit                img [H][W];
    logic [SW-1:0]     sti_mem [NWORDS];
    logic [DIST_W-1:0] res_mem [N];
    logic              fill_req;
    int                rd_cnt   = 0;
    int                wr_cnt   = 0;
    int                both_cnt = 0;
    int                checks   = 0;
    int                errors   = 0;

    dt_param_engine #(
        .W_LOG2 (W_LOG2),
        .H_LOG2 (H_LOG2),
        .SW_LOG2(SW_LOG2),
        .DIST_W (DIST_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .sti_rd  (sti_rd),
        .sti_addr(sti_addr),
        .sti_di  (sti_di),
        .res_rd  (res_rd),
        .res_wr  (res_wr),
        .res_addr(res_addr),
        .res_do  (res_do),
        .res_di  (res_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational reads, RES written on the rising edge.
    assign sti_di = sti_mem[sti_addr];
    assign res_di = res_mem[res_addr];

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < N; i++) res_mem[i] <= DIST_W'($urandom);
        end else if (res_wr) begin
            res_mem[res_addr] <= res_do;
        end
        if (res_rd)           rd_cnt   <= rd_cnt + 1;
        if (res_wr)           wr_cnt   <= wr_cnt + 1;
        if (res_rd && res_wr) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctl"}, {59'd0, busy, done, sti_rd, res_rd, res_wr}, 64'd0);
        check({tag, " sti_addr"}, 64'(sti_addr), 64'd0);
        check({tag, " res_addr"}, 64'(res_addr), 64'd0);
        check({tag, " res_do"}, 64'(res_do), 64'd0);
    endtask

    function automatic bit inside_img(int r, int c);
        return (r >= 0) && (r < H) && (c >= 0) && (c < W);
    endfunction

    // Expected distance: smallest metric radius reaching a background or out-of-image pixel.
    function automatic int model_dist(int r, int c, bit m);
        int ar, ac, met;
        if (!img[r][c]) return 0;
        for (int d = 1; d < DMAX; d++) begin
            for (int dr = -d; dr <= d; dr++) begin
                for (int dc = -d; dc <= d; dc++) begin
                    ar  = (dr < 0) ? -dr : dr;
                    ac  = (dc < 0) ? -dc : dc;
                    met = m ? ar + ac : ((ar > ac) ? ar : ac);
                    if (met == d) begin
                        if (!inside_img(r + dr, c + dc)) return d;
                        if (!img[r + dr][c + dc]) return d;
                    end
                end
            end
        end
        return DMAX;
    endfunction

    // Number of in-image neighbours visited for an object pixel in one pass.
    function automatic int nbrs_inside(int r, int c, bit m, bit bwd);
        int n = 0;
        int s = bwd ? 1 : -1;
        if (m) begin
            n += int'(inside_img(r + s, c)) + int'(inside_img(r, c + s));
        end else begin
            n += int'(inside_img(r + s, c - 1)) + int'(inside_img(r + s, c)) +
                 int'(inside_img(r + s, c + 1)) + int'(inside_img(r, c + s));
        end
        return n;
    endfunction

    task automatic clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'b0;
    endtask

    task automatic set_rect(input int r0, input int c0, input int h, input int w);
        for (int r = r0; r < r0 + h; r++)
            for (int c = c0; c < c0 + w; c++) img[r][c] = 1'b1;
    endtask

    task automatic rand_img(input int dens);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = ($urandom_range(0, 99) < dens);
    endtask

    task automatic build_sti();
        for (int a = 0; a < NWORDS; a++)
            for (int b = 0; b < SW; b++)
                sti_mem[a][SW-1-b] = img[a / WPR][(a % WPR) * SW + b];
    endtask

    task automatic run_job(input bit m, input bit mid_start, input string tag);
        int k, obj, exp_cyc, exp_rd, cyc, rd0, wr0, both0;
        k      = m ? 2 : 4;
        obj    = 0;
        exp_rd = N;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (img[r][c]) begin
                    obj++;
                    exp_rd += nbrs_inside(r, c, m, 1'b0) + nbrs_inside(r, c, m, 1'b1);
                end
        exp_cyc = NWORDS + (N + k * obj) + (N + (k + 1) * obj) + 1;
        build_sti();
        @(negedge clk); fill_req = 1'b1;
        @(negedge clk); fill_req = 1'b0;
        rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
        start = 1'b1; mode = m;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom);
        check({tag, " busy_rise"}, 64'(busy), 64'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < exp_cyc + 100) begin
            start = mid_start && (cyc == 40);
            if (start) mode = ~m;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(done), 64'd1);
        check({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, " done_pulse_end"}, {62'd0, busy, done}, 64'd0);
        check({tag, " res_rd_count"}, 64'(rd_cnt - rd0), 64'(exp_rd));
        check({tag, " res_wr_count"}, 64'(wr_cnt - wr0), 64'(N + obj));
        check({tag, " rd_wr_overlap"}, 64'(both_cnt - both0), 64'd0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                check($sformatf("%s px(%0d,%0d)", tag, r, c),
                      64'(res_mem[r * W + c]), 64'(model_dist(r, c, m)));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; fill_req = 1'b0;
        clear_img();
        build_sti();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        clear_img();
        run_job(1'b0, 1'b0, "all_zero");

        clear_img(); img[5][5] = 1'b1;
        run_job(1'b0, 1'b0, "single_chess");
        check("single_chess centre", 64'(res_mem[5 * W + 5]), 64'd1);
        run_job(1'b1, 1'b0, "single_city");
        check("single_city centre", 64'(res_mem[5 * W + 5]), 64'd1);

        clear_img(); set_rect(9, 9, 3, 3);
        run_job(1'b0, 1'b0, "sq3_chess");
        check("sq3_chess centre", 64'(res_mem[10 * W + 10]), 64'd2);
        check("sq3_chess corner", 64'(res_mem[9 * W + 9]), 64'd1);
        run_job(1'b1, 1'b0, "sq3_city");
        check("sq3_city centre", 64'(res_mem[10 * W + 10]), 64'd2);
        check("sq3_city corner", 64'(res_mem[11 * W + 11]), 64'd1);

        clear_img(); img[0][0] = 1'b1; img[H-1][W-1] = 1'b1;
        run_job(1'b0, 1'b0, "corners_chess");
        check("corners_chess first", 64'(res_mem[0]), 64'd1);
        check("corners_chess last", 64'(res_mem[N-1]), 64'd1);
        run_job(1'b1, 1'b0, "corners_city");

        clear_img(); set_rect(6, 6, 20, 20);
        run_job(1'b0, 1'b0, "sq20_chess");
        check("sq20_chess cap", 64'(res_mem[15 * W + 15]), 64'(DMAX));
        run_job(1'b1, 1'b1, "sq20_city");
        check("sq20_city cap", 64'(res_mem[16 * W + 16]), 64'(DMAX));

        rand_img(35);
        run_job(1'(1'($urandom)), 1'b1, "rand35");
        rand_img(70);
        run_job(1'b0, 1'b1, "rand70");
        rand_img(90);
        run_job(1'b1, 1'b0, "rand90");

        // Abort part-way through the forward pass, then restart the same image.
        rand_img(60);
        build_sti();
        @(negedge clk); start = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        @(posedge clk); #1;
        check_idle_outputs("reset_mid_edge");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'd0);
        run_job(1'b0, 1'b1, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
